// File: rtl/input_line_filter.sv
// Purpose : conditions WIDTH raw asynchronous bus lines (sync chain, glitch filter,
//           registered rise/fall pulses) before sniffing/injection logic consumes them.
// Latency : raw change to out_line change = SYNC_STAGES + FILTER_LEN edges; bypass = SYNC_STAGES + 1.
// Backpressure: none; lines are sampled levels every cycle, consumers cannot stall this block.
//
// Ports:
//   sys_clk    in   1      system clock, all state on rising edge
//   n_reset    in   1      synchronous reset, active-low, overrides everything
//   in_raw     in   WIDTH  asynchronous raw bus lines from pins
//   filter_en  in   WIDTH  per line: 1 = glitch filter active, 0 = bypass (sync chain kept)
//   out_line   out  WIDTH  conditioned line levels (registered)
//   rise_edge  out  WIDTH  one-cycle pulse when an out_line bit goes 0->1
//   fall_edge  out  WIDTH  one-cycle pulse when an out_line bit goes 1->0
//   any_edge   out  1      OR of all rise/fall bits, asserted in the same cycle
module input_line_filter #(
    parameter int              WIDTH       = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0] IDLE_LEVEL = '0
) (
    input  logic             sys_clk,
    input  logic             n_reset,
    input  logic [WIDTH-1:0] in_raw,
    input  logic [WIDTH-1:0] filter_en,
    output logic [WIDTH-1:0] out_line,
    output logic [WIDTH-1:0] rise_edge,
    output logic [WIDTH-1:0] fall_edge,
    output logic             any_edge
);

    // A single-cycle filter still needs a one-bit counter so the datapath stays uniform.
    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    // Count value at which a pending level has been seen FILTER_LEN times in a row.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_d;
    logic [WIDTH-1:0]                  out_line_q;
    logic [WIDTH-1:0]                  out_line_d;
    logic [WIDTH-1:0]                  rise_edge_q;
    logic [WIDTH-1:0]                  rise_edge_d;
    logic [WIDTH-1:0]                  fall_edge_q;
    logic [WIDTH-1:0]                  fall_edge_d;
    logic                              any_edge_q;
    logic                              any_edge_d;

    // Output of the last synchroniser stage; the only view of the pins the filter ever uses.
    logic [WIDTH-1:0]                  sync_line;

    assign sync_line = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Synchroniser chain: pure shift, no logic between the pin and stage 0.
    // ------------------------------------------------------------------
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // ------------------------------------------------------------------
    // Per-line stability filter.
    // The counter tracks how many consecutive synced cycles the line has
    // differed from the accepted level. Any return to the accepted level
    // clears it, so short excursions never accumulate into an acceptance.
    // Bypass copies the synced level straight through and keeps the counter
    // at zero, so re-enabling the filter always starts a fresh count.
    // ------------------------------------------------------------------
    always_comb begin
        out_line_d = out_line_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (!filter_en[i]) begin
                out_line_d[i] = sync_line[i];
                cnt_d[i]      = '0;
            end else if (sync_line[i] == out_line_q[i]) begin
                cnt_d[i]      = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                out_line_d[i] = sync_line[i];
                cnt_d[i]      = '0;
            end else begin
                cnt_d[i]      = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge pulses are derived from the next/current accepted level so they
    // are registered in the same edge that updates out_line. A bit can only
    // move one way per cycle, so rise and fall are mutually exclusive.
    // ------------------------------------------------------------------
    always_comb begin
        rise_edge_d = out_line_d & ~out_line_q;
        fall_edge_d = ~out_line_d & out_line_q;
        any_edge_d  = |(rise_edge_d | fall_edge_d);
    end

    // ------------------------------------------------------------------
    // Registers. Reset loads the idle level everywhere, including the
    // synchroniser, so lines whose pins sit away from idle at release
    // produce a normal, fully-latent edge pulse afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!n_reset) begin
            sync_q      <= {SYNC_STAGES{IDLE_LEVEL}};
            cnt_q       <= '0;
            out_line_q  <= IDLE_LEVEL;
            rise_edge_q <= '0;
            fall_edge_q <= '0;
            any_edge_q  <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            out_line_q  <= out_line_d;
            rise_edge_q <= rise_edge_d;
            fall_edge_q <= fall_edge_d;
            any_edge_q  <= any_edge_d;
        end
    end

    assign out_line  = out_line_q;
    assign rise_edge = rise_edge_q;
    assign fall_edge = fall_edge_q;
    assign any_edge  = any_edge_q;

endmodule

// File: tb/tb_input_line_filter.sv
// Purpose : checks input_line_filter at defaults (WIDTH=4, SYNC=2, FILTER=3, idle 0).
// Latency : each table row is one clock; its expected outputs are those after that edge.
// Backpressure: none; driver and monitor run free, linked by an expectation queue.
module tb_input_line_filter;

    logic       sys_clk = 1'b0;
    logic       n_reset;
    logic [3:0] in_raw;
    logic [3:0] filter_en;
    logic [3:0] out_line;
    logic [3:0] rise_edge;
    logic [3:0] fall_edge;
    logic       any_edge;

    always #5 sys_clk = ~sys_clk;

    input_line_filter #(
        .WIDTH      (4),
        .SYNC_STAGES(2),
        .FILTER_LEN (3),
        .IDLE_LEVEL (4'b0000)
    ) dut (
        .sys_clk  (sys_clk),
        .n_reset  (n_reset),
        .in_raw   (in_raw),
        .filter_en(filter_en),
        .out_line (out_line),
        .rise_edge(rise_edge),
        .fall_edge(fall_edge),
        .any_edge (any_edge)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] raw;
        logic [3:0] en;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   mon_idx = 0;

    function automatic void addn(int n, logic r, logic [3:0] raw, logic [3:0] en,
                                 logic [3:0] out, logic [3:0] rise, logic [3:0] fall);
        vec_t v;
        v.rst_n = r;
        v.raw   = raw;
        v.en    = en;
        v.out   = out;
        v.rise  = rise;
        v.fall  = fall;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h expected %h", name, mon_idx, act, exp);
        end
    endtask

    // Monitor: pops the expectation for the inputs present at the edge just taken.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                vec_t e;
                e = exp_q.pop_front();
                n_vec++;
                chk("out_line",  out_line,  e.out);
                chk("rise_edge", rise_edge, e.rise);
                chk("fall_edge", fall_edge, e.fall);
                chk("any_edge",  {3'b000, any_edge}, {3'b000, |(e.rise | e.fall)});
                chk("rise_and_fall_overlap", rise_edge & fall_edge, 4'h0);
                mon_idx++;
            end
        end
    end

    initial begin
        n_reset   = 1'b0;
        in_raw    = 4'h0;
        filter_en = 4'hF;

        //    n  rst raw    en     out    rise   fall
        // Reset held 4 cycles with pins high, then release: all lines rise 5 edges later.
        addn(4, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(4, 1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        addn(2, 1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0);
        // All lines drop together: simultaneous fall pulses.
        addn(4, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF);
        addn(2, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

        // Step on line 0: rise then fall, 5-edge latency each.
        addn(4, 1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h1, 4'hF, 4'h1, 4'h1, 4'h0);
        addn(1, 1, 4'h1, 4'hF, 4'h1, 4'h0, 4'h0);
        addn(4, 1, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

        // Line 1 glitch of 2 cycles: rejected.
        addn(2, 1, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(6, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        // Line 1 pulse of 3 cycles: accepted, high for exactly 3 cycles.
        addn(3, 1, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h2, 4'h2, 4'h0);
        addn(2, 1, 4'h0, 4'hF, 4'h2, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h2);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

        // Line 2 chatter 1,1,0,1,1,1: the 0 restarts the count; rise 3 synced cycles into final run.
        addn(2, 1, 4'h4, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(3, 1, 4'h4, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h4, 4'h4, 4'h0);
        addn(2, 1, 4'h0, 4'hF, 4'h4, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h4);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

        // Line 0 bypassed: 1-cycle raw pulse passes through after the sync chain.
        addn(1, 1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hE, 4'h1, 4'h1, 4'h0);
        addn(1, 1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h1);
        addn(1, 1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0);

        // Line 0 counts to 2, one bypass cycle while synced low, then a 3-cycle run:
        // no spurious pulse, and acceptance needs a full fresh count.
        addn(2, 1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h1, 4'hE, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h1, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h1, 4'h1, 4'h0);
        addn(2, 1, 4'h0, 4'hF, 4'h1, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h1);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

        // Reset while line 3 is at cnt=2: no pulse, then a full-latency rise after release.
        addn(4, 1, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 0, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(4, 1, 4'h8, 4'hF, 4'h0, 4'h0, 4'h0);
        addn(1, 1, 4'h8, 4'hF, 4'h8, 4'h8, 4'h0);
        addn(4, 1, 4'h0, 4'hF, 4'h8, 4'h0, 4'h0);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h8);
        addn(1, 1, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0);

        foreach (vecs[i]) begin
            @(negedge sys_clk);
            n_reset   = vecs[i].rst_n;
            in_raw    = vecs[i].raw;
            filter_en = vecs[i].en;
            exp_q.push_back(vecs[i]);
        end

        repeat (3) @(posedge sys_clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        if (n_vec != vecs.size()) begin
            n_err++;
            $display("FAIL vector_count: got %0d required %0d", n_vec, vecs.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
